// File: rtl/zigbee_symbol_sequencer.sv
// Symbol sequencer for the 802.15.4 transmit path: holds a 16-bit word, steps the
// 4:1 nibble mux select at symbol rate and emits chip/symbol strobes.
module zigbee_symbol_sequencer #(
   parameter int unsigned CHIP_DIV      = 4,
   parameter int unsigned CHIPS_PER_SYM = 32
) (
   input  logic        inClk,
   input  logic        inRst,
   input  logic [15:0] inWord,
   input  logic        inWordValid,
   output logic        outWordReady,
   input  logic        inFlush,
   output logic [15:0] outData,
   output logic [1:0]  outSel,
   output logic        outChipEn,
   output logic        outSymStart,
   output logic        outLastSym,
   output logic        outBusy
);

   localparam logic [3:0] DivLast  = 4'(CHIP_DIV - 1);
   localparam logic [4:0] ChipLast = 5'(CHIPS_PER_SYM - 1);

   typedef enum logic {StIdle, StRun} stateE;

   stateE       stateQ, stateD;
   logic [3:0]  divQ, divD;
   logic [4:0]  chipQ, chipD;
   logic [1:0]  slotQ, slotD;
   logic [15:0] dataQ, dataD;
   logic        chipEnQ, chipEnD;
   logic        symStartQ, symStartD;
   logic        terminal;
   logic        transfer;

   always_comb begin
      terminal     = (stateQ == StRun) && (slotQ == 2'd3) && (chipQ == ChipLast) &&
                     (divQ == DivLast);
      // Flush wins over a simultaneous transfer, so it masks ready outright.
      outWordReady = !inFlush && ((stateQ == StIdle) || terminal);
      transfer     = inWordValid && outWordReady;

      stateD = stateQ;
      divD   = divQ;
      chipD  = chipQ;
      slotD  = slotQ;
      dataD  = dataQ;

      unique case (stateQ)
         StIdle: begin
            if (transfer) begin
               dataD  = inWord;
               divD   = '0;
               chipD  = '0;
               slotD  = '0;
               stateD = StRun;
            end
         end
         StRun: begin
            if (inFlush || terminal) begin
               divD  = '0;
               chipD = '0;
               slotD = '0;
               if (transfer) begin
                  dataD = inWord;
               end else begin
                  stateD = StIdle;
               end
            end else if (divQ == DivLast) begin
               divD = '0;
               if (chipQ == ChipLast) begin
                  chipD = '0;
                  slotD = slotQ + 2'd1;
               end else begin
                  chipD = chipQ + 5'd1;
               end
            end else begin
               divD = divQ + 4'd1;
            end
         end
      endcase

      // Strobes are decoded from next state so they leave a flop clean.
      chipEnD   = (stateD == StRun) && (divD == 4'd0);
      symStartD = chipEnD && (chipD == 5'd0);
   end

   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         stateQ    <= StIdle;
         divQ      <= '0;
         chipQ     <= '0;
         slotQ     <= '0;
         dataQ     <= '0;
         chipEnQ   <= 1'b0;
         symStartQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         divQ      <= divD;
         chipQ     <= chipD;
         slotQ     <= slotD;
         dataQ     <= dataD;
         chipEnQ   <= chipEnD;
         symStartQ <= symStartD;
      end
   end

   assign outData     = dataQ;
   assign outSel      = slotQ;
   assign outChipEn   = chipEnQ;
   assign outSymStart = symStartQ;
   assign outLastSym  = (stateQ == StRun) && (slotQ == 2'd3);
   assign outBusy     = (stateQ == StRun);

endmodule

// File: tb/tb_zigbee_symbol_sequencer.sv
// Bench for zigbee_symbol_sequencer: directed vector table, random traffic against a
// word-timeline model, async reset and a CHIP_DIV=1 instance.
module tb_zigbee_symbol_sequencer;

   localparam int unsigned Cd      = 4;
   localparam int unsigned SymLen  = 32 * Cd;
   localparam int unsigned WordLen = 4 * SymLen;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] word;
   logic        valid, flush, ready;
   logic [15:0] data;
   logic [1:0]  sel;
   logic        chipEn, symStart, lastSym, busy;

   logic [15:0] word1;
   logic        valid1, ready1;
   logic [15:0] data1;
   logic [1:0]  sel1;
   logic        chipEn1, symStart1, lastSym1, busy1;

   int nCheck = 0;
   int nPass  = 0;

   // Model: a word is a timeline of WordLen cycles; everything derives from offset mT.
   bit          mBusy;
   int unsigned mT;
   logic [15:0] mData;

   always #5 clk = ~clk;

   zigbee_symbol_sequencer #(.CHIP_DIV(Cd)) dut (
      .inClk(clk), .inRst(rst), .inWord(word), .inWordValid(valid), .outWordReady(ready),
      .inFlush(flush), .outData(data), .outSel(sel), .outChipEn(chipEn),
      .outSymStart(symStart), .outLastSym(lastSym), .outBusy(busy)
   );

   zigbee_symbol_sequencer #(.CHIP_DIV(1)) dut1 (
      .inClk(clk), .inRst(rst), .inWord(word1), .inWordValid(valid1), .outWordReady(ready1),
      .inFlush(1'b0), .outData(data1), .outSel(sel1), .outChipEn(chipEn1),
      .outSymStart(symStart1), .outLastSym(lastSym1), .outBusy(busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCheck++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Starts and ends at a falling edge; compares, then advances the model on the edge.
   task automatic cycle(input logic v, input logic [15:0] w, input logic f);
      logic [1:0] eSel;
      logic       eReady;
      valid = v;
      word  = w;
      flush = f;
      #1;
      eSel   = mBusy ? 2'(mT / SymLen) : 2'd0;
      eReady = !f && (!mBusy || (mT == WordLen - 1));
      check("cycle", 32'({data, sel, chipEn, symStart, lastSym, busy, ready}),
            32'({mData, eSel, mBusy && (mT % Cd == 0), mBusy && (mT % SymLen == 0),
                 mBusy && (eSel == 2'd3), mBusy, eReady}));
      @(posedge clk);
      if (mBusy && f) begin
         mBusy = 1'b0;
      end else if (v && eReady) begin
         mBusy = 1'b1;
         mT    = 0;
         mData = w;
      end else if (mBusy) begin
         if (mT == WordLen - 1) mBusy = 1'b0;
         else mT++;
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic        v;
      logic [15:0] w;
      logic        f;
      int          n;
      logic        eBusy;
      logic [1:0]  eSel;
      logic [15:0] eData;
      logic        eReady;
   } vecT;

   vecT vecs[16];

   initial begin
      // Offsets in comments are cycles into the current word after the record.
      vecs[0]  = '{1'b1, 16'hA5C3, 1'b0, 1,   1'b1, 2'd0, 16'hA5C3, 1'b0}; // t=0
      vecs[1]  = '{1'b0, 16'h0000, 1'b0, 128, 1'b1, 2'd1, 16'hA5C3, 1'b0}; // t=128
      vecs[2]  = '{1'b0, 16'h0000, 1'b0, 256, 1'b1, 2'd3, 16'hA5C3, 1'b0}; // t=384
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 127, 1'b1, 2'd3, 16'hA5C3, 1'b1}; // terminal
      vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1,   1'b0, 2'd0, 16'hA5C3, 1'b1}; // idle
      vecs[5]  = '{1'b1, 16'h1234, 1'b0, 1,   1'b1, 2'd0, 16'h1234, 1'b0};
      vecs[6]  = '{1'b1, 16'hBEEF, 1'b0, 511, 1'b1, 2'd3, 16'h1234, 1'b1};
      vecs[7]  = '{1'b1, 16'hBEEF, 1'b0, 1,   1'b1, 2'd0, 16'hBEEF, 1'b0}; // no gap
      vecs[8]  = '{1'b0, 16'h0000, 1'b0, 10,  1'b1, 2'd0, 16'hBEEF, 1'b0};
      vecs[9]  = '{1'b1, 16'h0F0F, 1'b0, 501, 1'b1, 2'd3, 16'hBEEF, 1'b1};
      vecs[10] = '{1'b1, 16'h0F0F, 1'b0, 1,   1'b1, 2'd0, 16'h0F0F, 1'b0};
      vecs[11] = '{1'b0, 16'h0000, 1'b0, 200, 1'b1, 2'd1, 16'h0F0F, 1'b0};
      vecs[12] = '{1'b0, 16'h0000, 1'b1, 1,   1'b0, 2'd0, 16'h0F0F, 1'b1}; // flush
      vecs[13] = '{1'b1, 16'h00FF, 1'b0, 1,   1'b1, 2'd0, 16'h00FF, 1'b0};
      vecs[14] = '{1'b0, 16'h0000, 1'b0, 511, 1'b1, 2'd3, 16'h00FF, 1'b1};
      vecs[15] = '{1'b1, 16'h1111, 1'b1, 1,   1'b0, 2'd0, 16'h00FF, 1'b1}; // flush wins

      rst    = 1'b1;
      valid  = 1'b0;
      flush  = 1'b0;
      word   = '0;
      valid1 = 1'b0;
      word1  = '0;
      mBusy  = 1'b0;
      mT     = 0;
      mData  = '0;
      repeat (2) @(negedge clk);
      check("reset", 32'({data, sel, chipEn, symStart, lastSym, busy, ready}), 32'h1);
      rst = 1'b0;

      foreach (vecs[i]) begin
         for (int c = 0; c < vecs[i].n; c++) cycle(vecs[i].v, vecs[i].w, vecs[i].f);
         valid = 1'b0;
         flush = 1'b0;
         #1;
         check($sformatf("vec%0d", i), 32'({busy, sel, data, ready}),
               32'({vecs[i].eBusy, vecs[i].eSel, vecs[i].eData, vecs[i].eReady}));
      end

      // Terminal-cycle flush with valid: ready must stay low while flush is high.
      cycle(1'b1, 16'h2468, 1'b0);
      for (int c = 0; c < WordLen - 1; c++) cycle(1'b0, 16'h0, 1'b0);
      valid = 1'b1;
      flush = 1'b1;
      #1;
      check("flushReady", 32'(ready), 32'(0));
      cycle(1'b1, 16'h1357, 1'b1);
      check("flushIdle", 32'({busy, data}), 32'({1'b0, 16'h2468}));

      for (int c = 0; c < 4000; c++)
         cycle(1'($urandom % 2), 16'($urandom), 1'(($urandom % 1024) == 0));

      // Async reset mid-symbol, between edges.
      while (busy) cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b1, 16'h5A5A, 1'b0);
      for (int c = 0; c < 300; c++) cycle(1'b0, 16'h0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("asyncRst", 32'({data, sel, chipEn, symStart, lastSym, busy}), 32'(0));
      mBusy = 1'b0;
      mT    = 0;
      mData = '0;
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b1, 16'hC0DE, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);

      // CHIP_DIV=1: 128-cycle word, chip strobe on every RUN cycle.
      valid1 = 1'b1;
      word1  = 16'h3C3C;
      #1;
      check("cd1Ready", 32'(ready1), 32'(1));
      @(negedge clk);
      valid1 = 1'b0;
      for (int t = 0; t < 128; t++) begin
         #1;
         check($sformatf("cd1 t=%0d", t),
               32'({data1, sel1, chipEn1, symStart1, lastSym1, busy1, ready1}),
               32'({16'h3C3C, 2'(t / 32), 1'b1, (t % 32) == 0, (t / 32) == 3, 1'b1,
                    t == 127}));
         @(negedge clk);
      end
      #1;
      check("cd1End", 32'({sel1, chipEn1, symStart1, busy1, ready1}), 32'h1);

      $display("%0d/%0d checks passed", nPass, nCheck);
      $finish;
   end

endmodule

// File: doc/zigbee_symbol_sequencer.md
Name: zigbee_symbol_sequencer

Overview:
- Upstream stage of the 4:1 nibble multiplexer in the 802.15.4 transmit path.
- Accepts 16-bit payload words over a valid/ready handshake and holds each word stable on outData.
- Steps outSel through the four symbol slots (00,01,10,11) at symbol rate and emits chip/symbol timing strobes for the downstream chip spreader.
- One symbol = 32 chips; one chip = CHIP_DIV clock cycles.

Parameters:
CHIP_DIV, 4, clock cycles per chip (legal range 1..16)
CHIPS_PER_SYM, 32, chips per 4-bit symbol (fixed by 802.15.4 O-QPSK; not intended to be overridden)

Ports:
inClk  input  1  system clock, all logic on rising edge
inRst  input  1  asynchronous, active-high reset
inWord  input  16  payload word; symbol 0 = nibble [3:0] ... symbol 3 = nibble [15:12]
inWordValid  input  1  inWord valid
outWordReady  output  1  sequencer accepts inWord this cycle
inFlush  input  1  synchronous abort of the current word
outData  output  16  held word, drives the multiplexer data input
outSel  output  2  symbol slot index, drives the multiplexer select
outChipEn  output  1  one-cycle strobe at the start of each chip
outSymStart  output  1  one-cycle strobe at the start of each symbol (coincides with outChipEn)
outLastSym  output  1  high for the whole duration of symbol slot 3
outBusy  output  1  high while in RUN

Behaviour:
- Reset (async, inRst=1): state=IDLE; outData=0, outSel=00, outChipEn=0, outSymStart=0, outLastSym=0, outBusy=0; divider, chip and slot counters=0. outWordReady=1 once inRst deasserts (combinational from state).
- States: IDLE, RUN.
- Transfer occurs when inWordValid && outWordReady at a rising edge.
- IDLE:
  - outWordReady=1.
  - On transfer: outData<=inWord, counters<=0, state<=RUN.
  - Otherwise outData holds its last value and outSel=00.
- RUN counters:
  - div_cnt counts 0..CHIP_DIV-1, then wraps.
  - chip_cnt increments when div_cnt wraps, 0..31.
  - slot (=outSel) increments when chip_cnt wraps from 31.
- RUN strobes:
  - outChipEn=1 when div_cnt==0 (registered-equivalent, glitch-free).
  - outSymStart=1 when div_cnt==0 && chip_cnt==0.
  - outLastSym=(slot==3). outBusy=1.
- Latency: word accepted at edge k → at edge k+1 outBusy=1, outSel=00, outSymStart=1.
- Word duration = 4*32*CHIP_DIV cycles (512 cycles at default).
- End of word (terminal cycle: slot==3, chip_cnt==31, div_cnt==CHIP_DIV-1):
  - outWordReady=1 in this cycle only; it is 0 during the rest of RUN.
  - If transfer: load the new word, counters<=0, stay in RUN. Next cycle is symbol 0 of the new word with outSymStart=1; no gap cycle.
  - Else: state<=IDLE; outSel<=00; outData holds.
- inFlush:
  - Sampled every cycle. If 1 in RUN: state<=IDLE, counters<=0, strobes 0 next cycle, outData holds.
  - inFlush has priority over a simultaneous transfer in the terminal cycle: the word is not accepted, and outWordReady is forced to 0 while inFlush=1.
  - inFlush in IDLE has no effect other than blocking the transfer.
- outData and outSel change only at word load or slot advance. They never change mid-symbol.
- inWord is ignored when no transfer occurs.
- Reset asserted mid-word: immediate return to reset values. The partial word is discarded and not resumed.

Test Plan:
- Reset then single word: inRst pulse, then inWord=16'hA5C3 with valid for 1 cycle → outWordReady drops next cycle; outData=A5C3; outSel 00/01/10/11 for 128 cycles each; outChipEn every 4th cycle (128 pulses); outSymStart at cycle offsets 0,128,256,384; outLastSym high for cycles 384..511; IDLE at cycle 512 with outSel=00.
- Back-to-back: inWordValid held high with words 16'h1234 then 16'hBEEF → second word loaded exactly 512 cycles after the first; outSymStart at cycle 512; zero idle cycles; outData switches on the same edge as outSel wraps to 00.
- Held valid while busy: inWordValid=1 with 16'h0F0F from cycle 10 of a word → no transfer until the terminal cycle; outWordReady is high on exactly one cycle per word.
- Flush: inFlush=1 at cycle 200 (slot 01) → next cycle outBusy=0, outSel=00, no strobes; then new word 16'h00FF → clean restart at slot 00.
- Flush and transfer on the terminal cycle → outWordReady=0, word not consumed, IDLE next cycle.
- Async reset mid-symbol (inRst asserted between clock edges at cycle 300) → outputs 0 immediately, before the next edge; CHIP_DIV=1 regression: word duration 128 cycles and outChipEn high every RUN cycle.
